// File: rtl/uartprobe_host.sv
// Host-side initiator for the UART probe byte protocol: serialises one GPI/GPO
// request into command/data bytes and assembles the probe's read replies.
module uartprobe_host #(
    parameter int unsigned RSP_TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        rx_stray
);

    localparam int unsigned CNT_W = (RSP_TIMEOUT < 2) ? 1 : $clog2(RSP_TIMEOUT + 1);
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_CMD,
        S_SEND_DATA,
        S_WAIT_RSP,
        S_RESP
    } state_t;

    state_t             state;
    logic [1:0]         op;
    logic [31:0]        wdata;
    logic [1:0]         lane;
    logic [CNT_W-1:0]   cnt;

    assign rx_ready = 1'b1;

    function automatic logic [7:0] cmd_code(input logic [1:0] o, input logic [1:0] l);
        logic [7:0] base;
        case (o)
            2'b00:   base = 8'd2;
            2'b01:   base = 8'd6;
            default: base = 8'd10;
        endcase
        return base + {6'd0, l};
    endfunction

    function automatic logic [7:0] wr_byte(input logic [31:0] w, input logic [1:0] l);
        logic [7:0] b;
        case (l)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= S_IDLE;
            op        <= 2'b00;
            wdata     <= 32'd0;
            lane      <= 2'd0;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= 8'd0;
            rx_stray  <= 1'b0;
        end else begin
            // Only WAIT_RSP consumes probe bytes; anything else is flagged and dropped
            rx_stray <= rx_valid && (state != S_WAIT_RSP);
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op        <= req_op;
                        wdata     <= req_wdata;
                        lane      <= 2'd0;
                        rsp_rdata <= 32'd0;
                        req_ready <= 1'b0;
                        if (req_op == OP_RSVD) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            state    <= S_SEND_CMD;
                            rsp_err  <= 1'b0;
                            tx_valid <= 1'b1;
                            tx_data  <= cmd_code(req_op, 2'd0);
                        end
                    end
                end
                S_SEND_CMD: begin
                    if (tx_ready) begin
                        if (op == OP_WRITE) begin
                            state   <= S_SEND_DATA;
                            tx_data <= wr_byte(wdata, lane);
                        end else begin
                            state    <= S_WAIT_RSP;
                            tx_valid <= 1'b0;
                            cnt      <= '0;
                        end
                    end
                end
                S_SEND_DATA: begin
                    if (tx_ready) begin
                        if (lane == 2'd3) begin
                            state     <= S_RESP;
                            tx_valid  <= 1'b0;
                            rsp_valid <= 1'b1;
                        end else begin
                            state   <= S_SEND_CMD;
                            lane    <= lane + 2'd1;
                            tx_data <= cmd_code(op, lane + 2'd1);
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (rx_valid) begin
                        // RD0 lands in the most significant byte
                        case (lane)
                            2'd0:    rsp_rdata[31:24] <= rx_data;
                            2'd1:    rsp_rdata[23:16] <= rx_data;
                            2'd2:    rsp_rdata[15:8]  <= rx_data;
                            default: rsp_rdata[7:0]   <= rx_data;
                        endcase
                        if (lane == 2'd3) begin
                            state     <= S_RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            state    <= S_SEND_CMD;
                            lane     <= lane + 2'd1;
                            tx_valid <= 1'b1;
                            tx_data  <= cmd_code(op, lane + 2'd1);
                        end
                    end else if ((RSP_TIMEOUT != 0) && (cnt == CNT_W'(RSP_TIMEOUT - 1))) begin
                        state     <= S_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    tx_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uartprobe_host.sv
// Randomised bench for uartprobe_host: a probe model answers reads while a
// transaction-level model predicts the TX byte stream and the completion.
module tb_uartprobe_host;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        areset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_stray;

    int total = 0;
    int bad   = 0;

    uartprobe_host #(.RSP_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .areset    (areset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_stray  (rx_stray)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // silent: read lane whose reply never comes (4 = all lanes answered)
    task automatic run_txn(input logic [1:0] op, input logic [31:0] wdata, input logic [31:0] reply,
                           input int silent, input int stall_pct, input int fixed_stall);
        logic [7:0]  exp_tx[$];
        logic [7:0]  got_tx[$];
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        prev_stall;
        logic [7:0]  prev_data;
        logic        done;
        logic [31:0] held_rdata;
        logic        held_err;
        int          pending, cyc, last_hs, k_rd, stall_left, exp_gap, hold;

        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        if (op == 2'b11) begin
            exp_err = 1'b1;
        end else if (op == 2'b10) begin
            for (int k = 0; k < 4; k++) begin
                exp_tx.push_back(8'(10 + k));
                exp_tx.push_back(wdata[8*k +: 8]);
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                exp_tx.push_back(8'((op == 2'b00 ? 2 : 6) + k));
                if (k == silent) begin
                    exp_err = 1'b1;
                    break;
                end
                exp_rdata[31-8*k -: 8] = reply[31-8*k -: 8];
            end
        end
        exp_gap = (exp_err && op != 2'b11) ? int'(TMO) + 1 : 1;

        check("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_wdata = wdata;
        step();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_wdata = $urandom;
        check("ready_drop", {31'd0, req_ready}, 32'd0);
        if (op != 2'b11) check("first_tx_lat", {31'd0, tx_valid}, 32'd1);

        pending = -1; k_rd = 0; last_hs = -1; cyc = 0;
        prev_stall = 1'b0; prev_data = 8'd0; stall_left = fixed_stall; done = 1'b0;
        while (!done && cyc < 400) begin
            check("no_stray", {31'd0, rx_stray}, 32'd0);
            if (prev_stall) check("tx_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, prev_data});
            if (rsp_valid) begin
                check("rsp_lat", cyc - last_hs, exp_gap);
                check("rsp_rdata", rsp_rdata, exp_rdata);
                check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
                check("tx_count", got_tx.size(), exp_tx.size());
                for (int i = 0; i < exp_tx.size() && i < got_tx.size(); i++)
                    check($sformatf("tx_byte%0d", i), {24'd0, got_tx[i]}, {24'd0, exp_tx[i]});
                check("tx_idle_in_resp", {31'd0, tx_valid}, 32'd0);
                held_rdata = rsp_rdata;
                held_err   = rsp_err;
                hold = $urandom_range(3);
                for (int h = 0; h < hold; h++) begin
                    step();
                    check("rsp_stable", {rsp_valid, rsp_err, rsp_rdata[29:0]},
                          {1'b1, exp_err, exp_rdata[29:0]});
                end
                rsp_ready = 1'b1;
                step();
                rsp_ready = 1'b0;
                check("rsp_drop", {30'd0, rsp_valid, req_ready}, 32'd1);
                done = 1'b1;
            end else begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                if (pending == 0) begin
                    rx_valid = 1'b1;
                    rx_data  = reply[31-8*k_rd -: 8];
                    k_rd++;
                    last_hs = cyc;
                    pending = -1;
                end else if (pending > 0) begin
                    pending--;
                end
                if (stall_left > 0 && tx_valid) begin
                    tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    tx_ready = ($urandom_range(99) >= stall_pct);
                end
                if (tx_valid && tx_ready) begin
                    got_tx.push_back(tx_data);
                    last_hs = cyc;
                    if (op != 2'b10 && k_rd != silent) pending = $urandom_range(5);
                end
                prev_stall = tx_valid && !tx_ready;
                prev_data  = tx_data;
                step();
                cyc++;
            end
        end
        check("txn_done", {31'd0, done}, 32'd1);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
    endtask

    initial begin
        areset    = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_wdata = 32'd0;
        rsp_ready = 1'b0;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        #3;
        check("rst_outs", {26'd0, req_ready, rsp_valid, rsp_err, tx_valid, rx_stray, rx_ready}, 32'b100001);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_txdata", {24'd0, tx_data}, 32'd0);
        #9 areset = 1'b0;
        step();

        run_txn(2'b10, 32'hA1B2C3D4, 32'd0, 4, 0, 0);
        run_txn(2'b00, 32'd0, 32'h12345678, 4, 0, 0);
        run_txn(2'b01, 32'd0, 32'h9ABCDEF0, 4, 0, 10);
        run_txn(2'b01, 32'd0, 32'hCAFEBEEF, 2, 0, 0);
        run_txn(2'b11, 32'h55AA55AA, 32'd0, 4, 0, 0);

        // Probe byte arriving while idle is discarded and flagged
        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        step();
        rx_valid = 1'b0;
        check("stray_pulse", {30'd0, rx_stray, rsp_valid}, 32'b10);
        step();
        check("stray_clear", {31'd0, rx_stray}, 32'd0);

        // Reset while the lane-2 data byte is being offered
        req_valid = 1'b1;
        req_op    = 2'b10;
        req_wdata = 32'h11223344;
        tx_ready  = 1'b1;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();
        tx_ready = 1'b0;
        check("pre_rst_byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'h22});
        #2 areset = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx_valid}, 32'd0);
        check("abort_state", {30'd0, req_ready, rsp_valid}, 32'b10);
        @(negedge clk);
        areset = 1'b0;
        step();
        check("post_rst", {29'd0, req_ready, rsp_valid, tx_valid}, 32'b100);
        run_txn(2'b00, 32'd0, 32'h0BADF00D, 4, 20, 0);

        for (int n = 0; n < 30; n++) begin
            run_txn(2'($urandom_range(3)), $urandom, $urandom,
                    ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 4, 30, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
